// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter unit.
package pc_pkg;

   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_TRAP,
      ACT_RET,
      ACT_CALL,
      ACT_BRANCH,
      ACT_INC
   } act_e;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_01F0;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the fetch controller (master) and pc_unit (slave).
interface pc_unit_if #(
   parameter int unsigned ADDR_W = 9
);
   logic              stall;
   logic              trap;
   logic              ret;
   logic              call;
   logic              branch;
   logic [ADDR_W-1:0] branch_address;
   logic              clear_err;
   logic [ADDR_W-1:0] pc_out;
   logic [ADDR_W-1:0] pc_next;
   logic              ras_empty;
   logic              ras_full;
   logic              ras_overflow;
   logic              ras_underflow;

   modport master (
      output stall, trap, ret, call, branch, branch_address, clear_err,
      input  pc_out, pc_next, ras_empty, ras_full, ras_overflow, ras_underflow
   );

   modport slave (
      input  stall, trap, ret, call, branch, branch_address, clear_err,
      output pc_out, pc_next, ras_empty, ras_full, ras_overflow, ras_underflow
   );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module ras_stack #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 9
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [ADDR_W-1:0] i_push_data,
   output logic [ADDR_W-1:0] o_top,
   output logic              o_empty,
   output logic              o_full,
   output logic              o_overflow_evt,
   output logic              o_underflow_evt
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_ptr;      // next free slot; top entry sits just below it
   logic [CNT_W-1:0]  r_count;

   logic [PTR_W-1:0]  w_ptr_inc;
   logic [PTR_W-1:0]  w_ptr_dec;
   logic              w_do_push;
   logic              w_do_pop;

   assign w_ptr_inc = (r_ptr == LAST_SLOT) ? '0 : r_ptr + PTR_W'(1);
   assign w_ptr_dec = (r_ptr == '0) ? LAST_SLOT : r_ptr - PTR_W'(1);

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == FULL_CNT);
   assign o_top   = r_mem[w_ptr_dec];

   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & ~i_pop;

   assign o_overflow_evt  = w_do_push & o_full;
   assign o_underflow_evt = i_pop & o_empty;

   // When full, the free-slot pointer coincides with the oldest entry.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr   <= '0;
         r_count <= '0;
      end else if (w_do_push) begin
         r_ptr <= w_ptr_inc;
         if (!o_full) begin
            r_count <= r_count + CNT_W'(1);
         end
      end else if (w_do_pop) begin
         r_ptr   <= w_ptr_dec;
         r_count <= r_count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: priority action select, PC register, sticky RAS error flags.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned ADDR_W    = 9,
   parameter int unsigned STEP      = 1,
   parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
   parameter logic [31:0] TRAP_VEC  = DEF_TRAP_VEC,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   pc_unit_if.slave   bus
);

   localparam logic [ADDR_W-1:0] STEP_W  = ADDR_W'(STEP);
   localparam logic [ADDR_W-1:0] RESET_W = ADDR_W'(RESET_VEC);
   localparam logic [ADDR_W-1:0] TRAP_W  = ADDR_W'(TRAP_VEC);

   logic [ADDR_W-1:0] r_pc;
   logic              r_overflow;
   logic              r_underflow;

   act_e              w_act;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_pc_next;
   logic [ADDR_W-1:0] w_ras_top;
   logic              w_ras_empty;
   logic              w_ras_full;
   logic              w_ovf_evt;
   logic              w_unf_evt;

   assign w_pc_inc = r_pc + STEP_W;

   always_comb begin
      w_act = ACT_INC;
      if (bus.stall)       w_act = ACT_HOLD;
      else if (bus.trap)   w_act = ACT_TRAP;
      else if (bus.ret)    w_act = ACT_RET;
      else if (bus.call)   w_act = ACT_CALL;
      else if (bus.branch) w_act = ACT_BRANCH;
   end

   always_comb begin
      w_pc_next = w_pc_inc;
      case (w_act)
         ACT_HOLD:   w_pc_next = r_pc;
         ACT_TRAP:   w_pc_next = TRAP_W;
         ACT_RET:    w_pc_next = w_ras_empty ? w_pc_inc : w_ras_top;
         ACT_CALL:   w_pc_next = bus.branch_address;
         ACT_BRANCH: w_pc_next = bus.branch_address;
         default:    w_pc_next = w_pc_inc;
      endcase
   end

   ras_stack #(
      .DEPTH  (RAS_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ras (
      .i_clk           (clk),
      .i_rst_n         (reset),
      .i_push          (w_act == ACT_CALL),
      .i_pop           (w_act == ACT_RET),
      .i_push_data     (w_pc_inc),
      .o_top           (w_ras_top),
      .o_empty         (w_ras_empty),
      .o_full          (w_ras_full),
      .o_overflow_evt  (w_ovf_evt),
      .o_underflow_evt (w_unf_evt)
   );

   // A new error event at the same edge as clear_err keeps the flag set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc        <= RESET_W;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_pc        <= w_pc_next;
         r_overflow  <= w_ovf_evt | (r_overflow  & ~bus.clear_err);
         r_underflow <= w_unf_evt | (r_underflow & ~bus.clear_err);
      end
   end

   assign bus.pc_out        = r_pc;
   assign bus.pc_next       = w_pc_next;
   assign bus.ras_empty     = w_ras_empty;
   assign bus.ras_full      = w_ras_full;
   assign bus.ras_overflow  = r_overflow;
   assign bus.ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expected PCs queued at drive time, popped after the edge.
module tb_pc_unit;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [8:0] exp_q [$];

   always #5 clk = ~clk;

   pc_unit_if #(.ADDR_W(9)) bus ();

   pc_unit #(
      .ADDR_W    (9),
      .STEP      (1),
      .RESET_VEC (32'h000),
      .TRAP_VEC  (32'h1F0),
      .RAS_DEPTH (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic flags(input string tag, input logic e, input logic f, input logic o, input logic u);
      chk({tag, ".empty"}, 9'(bus.ras_empty), 9'(e));
      chk({tag, ".full"},  9'(bus.ras_full),  9'(f));
      chk({tag, ".ovf"},   9'(bus.ras_overflow),  9'(o));
      chk({tag, ".unf"},   9'(bus.ras_underflow), 9'(u));
   endtask

   task automatic idle();
      bus.stall = 1'b0; bus.trap = 1'b0; bus.ret = 1'b0; bus.call = 1'b0;
      bus.branch = 1'b0; bus.branch_address = '0; bus.clear_err = 1'b0;
   endtask

   task automatic step(input string tag, input logic st, input logic tr, input logic rt,
                       input logic cl, input logic br, input logic [8:0] ba,
                       input logic ce, input logic [8:0] exp_pc);
      bus.stall = st; bus.trap = tr; bus.ret = rt; bus.call = cl;
      bus.branch = br; bus.branch_address = ba; bus.clear_err = ce;
      exp_q.push_back(exp_pc);
      #1 chk({tag, ".next"}, bus.pc_next, exp_pc);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s.queue observed empty expected entry", tag);
      end else begin
         chk({tag, ".pc"}, bus.pc_out, exp_q.pop_front());
      end
      idle();
      @(negedge clk);
   endtask

   task automatic inc(input string tag, input logic [8:0] exp_pc);
      step(tag, 0, 0, 0, 0, 0, 9'h000, 0, exp_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset = 1'b0;
      #3 chk("rst.hold", bus.pc_out, 9'h000);
      @(negedge clk);
      reset = 1'b1;
      #1 chk("rst.rel", bus.pc_out, 9'h000);
      flags("rst", 1, 0, 0, 0);

      // sequential advance, branch, stall
      inc("inc1", 9'h001);
      inc("inc2", 9'h002);
      inc("inc3", 9'h003);
      step("br23", 0, 0, 0, 0, 1, 9'h023, 0, 9'h023);
      inc("inc24", 9'h024);
      step("stall1", 1, 0, 0, 0, 0, 9'h000, 0, 9'h024);
      step("stall_trap", 1, 1, 0, 0, 0, 9'h000, 0, 9'h024);
      inc("inc25", 9'h025);

      // single call/return
      step("br10", 0, 0, 0, 0, 1, 9'h010, 0, 9'h010);
      step("call100", 0, 0, 0, 1, 0, 9'h100, 0, 9'h100);
      flags("call1", 0, 0, 0, 0);
      for (int unsigned i = 1; i <= 5; i++) inc("run", 9'(9'h100 + i));
      step("ret011", 0, 0, 1, 0, 0, 9'h000, 0, 9'h011);
      flags("ret1", 1, 0, 0, 0);

      // fill, overflow, drain, underflow, clear
      step("br001", 0, 0, 0, 0, 1, 9'h001, 0, 9'h001);
      for (int unsigned i = 1; i <= 4; i++)
         step("callN", 0, 0, 0, 1, 0, 9'(9'h100 + i), 0, 9'(9'h100 + i));
      flags("fill", 0, 1, 0, 0);
      step("call_ovf", 0, 0, 0, 1, 0, 9'h180, 0, 9'h180);
      flags("ovf", 0, 1, 1, 0);
      for (int unsigned i = 0; i < 4; i++)
         step("retN", 0, 0, 1, 0, 0, 9'h000, 0, 9'(9'h105 - i));
      flags("drain", 1, 0, 1, 0);
      step("ret_unf_clr", 0, 0, 1, 0, 0, 9'h000, 1, 9'h103);
      flags("unf_clr", 1, 0, 0, 1);
      step("clr", 0, 0, 0, 0, 0, 9'h000, 1, 9'h104);
      flags("clr", 1, 0, 0, 0);

      // wrap and priority
      step("br1ff", 0, 0, 0, 0, 1, 9'h1FF, 0, 9'h1FF);
      inc("wrap", 9'h000);
      step("br1ff_b", 0, 0, 0, 0, 1, 9'h1FF, 0, 9'h1FF);
      step("call_wrap", 0, 0, 0, 1, 0, 9'h050, 0, 9'h050);
      step("trap_prio", 0, 1, 1, 1, 0, 9'h077, 0, 9'h1F0);
      flags("trap", 0, 0, 0, 0);
      step("call_br", 0, 0, 0, 1, 1, 9'h060, 0, 9'h060);
      step("ret1f1", 0, 0, 1, 0, 0, 9'h000, 0, 9'h1F1);
      step("ret_wrap", 0, 0, 1, 0, 0, 9'h000, 0, 9'h000);
      flags("wrap", 1, 0, 0, 0);
      step("call_ret", 0, 0, 1, 1, 0, 9'h099, 0, 9'h001);
      flags("call_ret", 1, 0, 0, 1);

      // asynchronous reset mid-cycle
      step("br0a0", 0, 0, 0, 0, 1, 9'h0A0, 0, 9'h0A0);
      step("call0a5", 0, 0, 0, 1, 0, 9'h0A5, 0, 9'h0A5);
      step("call0aa", 0, 0, 0, 1, 0, 9'h0AA, 0, 9'h0AA);
      inc("inc0ab", 9'h0AB);
      flags("pre_rst", 0, 0, 0, 1);
      #2 reset = 1'b0;
      #1 chk("arst.pc", bus.pc_out, 9'h000);
      flags("arst", 1, 0, 0, 0);
      @(posedge clk);
      #1 chk("arst.held", bus.pc_out, 9'h000);
      @(negedge clk);
      reset = 1'b1;
      #1 chk("arst.rel", bus.pc_out, 9'h000);
      inc("post_rst", 9'h001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit, successor to the fixed 9-bit PC. It generates the fetch address each cycle and supports:
- sequential increment, branch, stall
- trap redirect to a fixed vector
- call/return through an internal circular return-address stack (RAS) with full/empty status and sticky error flags

It sits at the head of the fetch stage and drives instruction-memory addressing.

Parameters:
- ADDR_W, 9, width of PC and all address ports
- STEP, 1, increment added per sequential advance (modulo 2^ADDR_W)
- RESET_VEC, 0, PC value loaded on reset
- TRAP_VEC, 9'h1F0, PC value loaded on trap (truncated to ADDR_W)
- RAS_DEPTH, 4, return-stack entries (>=2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  one clock; reset is asynchronous and active-low (reset=0 resets)
- stall  in  1  freeze PC and RAS this cycle
- trap  in  1  redirect to TRAP_VEC
- ret  in  1  pop RAS, jump to popped address
- call  in  1  push pc_out+STEP, jump to branch_address
- branch  in  1  jump to branch_address
- branch_address  in  ADDR_W  branch/call target
- clear_err  in  1  clear sticky error flags
- pc_out  out  ADDR_W  current registered PC
- pc_next  out  ADDR_W  combinational value PC takes at next edge
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_overflow  out  1  sticky: call while full
- ras_underflow  out  1  sticky: ret while empty

Behaviour:
- Reset (async, reset=0): pc_out=RESET_VEC, RAS count=0, top pointer=0, ras_overflow=0, ras_underflow=0. Takes effect immediately, mid-cycle included. Outputs stay held while reset=0.
- Edge priority, one action per edge: stall > trap > ret > call > branch > increment.
- stall=1: PC, RAS and flags unchanged, except that clear_err still clears. pc_next=pc_out. A trap asserted during stall is ignored; the source must hold it.
- trap: pc <= TRAP_VEC. RAS unchanged.
- ret, RAS non-empty: pc <= top entry, count-1, pointer moves down.
- ret, RAS empty: pc <= pc_out+STEP; ras_underflow <= 1; count stays 0.
- call, RAS not full: write pc_out+STEP at next slot, count+1, pc <= branch_address.
- call, RAS full: overwrite oldest slot (circular), count stays RAS_DEPTH, ras_overflow <= 1, pc <= branch_address.
- branch: pc <= branch_address.
- Otherwise: pc <= pc_out+STEP.
- Simultaneous call and ret: ret wins, no push. Simultaneous call and branch: call.
- Arithmetic: all adds modulo 2^ADDR_W (0x1FF+1 -> 0x000 at ADDR_W=9). Pushed return address wraps likewise.
- Latency: a redirect is visible on pc_out one edge after the request; pc_next reflects it in the same cycle.
- clear_err=1 at an edge clears both sticky flags. If a new error event occurs at the same edge, the set wins.
- ras_empty and ras_full are combinational from the count, registered state only.

Decomposition:
- Package pc_pkg holds: the action-select encoding (ACT_HOLD, ACT_TRAP, ACT_RET, ACT_CALL, ACT_BRANCH, ACT_INC) and the default RESET_VEC/TRAP_VEC constants.
- One sub-module, ras_stack: circular buffer, pointer, count, push/pop, full/empty, overflow/underflow detect.
- pc_unit keeps the priority mux, PC register and sticky flags.

Test Plan (ADDR_W=9, STEP=1, RAS_DEPTH=4, TRAP_VEC=0x1F0):
1. Reset pulse low then released, no controls -> pc_out 0x000, 0x001, 0x002, 0x003 on successive edges; ras_empty=1, flags 0.
2. At pc 0x003: branch=1 with address 0x023 for one edge -> pc 0x023 then 0x024. Then stall=1 for two edges -> pc stays 0x024; stall=0 -> 0x025.
3. At pc 0x010: call to 0x100 -> pc 0x100, ras_empty=0. Run to 0x105, then ret -> pc 0x011, ras_empty=1.
4. Five calls (from 0x001, 0x101, 0x102, 0x103, 0x104 to successive targets) -> ras_full=1, ras_overflow=1 after the fifth. Four rets return 0x105, 0x104, 0x103, 0x102. A fifth ret -> pc+1, ras_underflow=1. Then clear_err -> both flags 0.
5. Wrap and priority checks:
   - Branch to 0x1FF then increment -> 0x000.
   - trap+ret+call same edge with RAS holding 1 entry -> pc 0x1F0, RAS count still 1.
6. Drive reset low between edges while pc=0x0AB with RAS count 2 -> pc_out 0x000 immediately, ras_empty=1, flags 0, with no clock edge required.
